// File: rtl/gpio_pkg.sv
// Shared register-map constants and bus widths for the padring GPIO side controllers.
package gpio_pkg;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] ADDR_OUT     = 4'h0;
    localparam logic [REG_AW-1:0] ADDR_OEN     = 4'h1;
    localparam logic [REG_AW-1:0] ADDR_IE      = 4'h2;
    localparam logic [REG_AW-1:0] ADDR_IN      = 4'h3;
    localparam logic [REG_AW-1:0] ADDR_RISE_EN = 4'h4;
    localparam logic [REG_AW-1:0] ADDR_FALL_EN = 4'h5;
    localparam logic [REG_AW-1:0] ADDR_STATUS  = 4'h6;
    localparam logic [REG_AW-1:0] ADDR_CFG0    = 4'h8;

    // CFG0..CFG7 occupy the upper half of the word address space
    function automatic logic is_cfg_addr(input logic [REG_AW-1:0] addr);
        return addr[REG_AW-1];
    endfunction

endpackage

// File: rtl/gpio_side_ctrl_if.sv
// Valid/ready register port: request channel plus a held read-response channel.
interface gpio_side_ctrl_if;
    import gpio_pkg::*;

    logic              reg_valid;
    logic              reg_ready;
    logic              reg_write;
    logic [REG_AW-1:0] reg_addr;
    logic [REG_DW-1:0] reg_wdata;
    logic              reg_rvalid;
    logic              reg_rready;
    logic [REG_DW-1:0] reg_rdata;

    modport master (
        output reg_valid, reg_write, reg_addr, reg_wdata, reg_rready,
        input  reg_ready, reg_rvalid, reg_rdata
    );

    modport slave (
        input  reg_valid, reg_write, reg_addr, reg_wdata, reg_rready,
        output reg_ready, reg_rvalid, reg_rdata
    );

endinterface

// File: rtl/gpio_sync.sv
// Parameterized-width two-flop synchronizer with synchronous active-high reset.
module gpio_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/gpio_side_ctrl.sv
// Core-side controller for one padring side: register file, pad drive, synchronized
// input sampling, edge detection with W1C status and a registered level interrupt.
module gpio_side_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO = 9,
    parameter int unsigned CFG_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    gpio_side_ctrl_if.slave           reg_port,
    input  logic [NUM_GPIO-1:0]       pad_din,
    output logic [NUM_GPIO-1:0]       pad_dout,
    output logic [NUM_GPIO-1:0]       pad_oen,
    output logic [NUM_GPIO-1:0]       pad_ie,
    output logic [NUM_GPIO*CFG_W-1:0] pad_cfg,
    output logic                      irq
);

    localparam int unsigned CFG_TOT = NUM_GPIO * CFG_W;
    localparam int unsigned CFG_PAD = 8 * REG_DW;

    logic [NUM_GPIO-1:0] out_q, oen_q, ie_q, rise_en_q, fall_en_q, status_q;
    logic [NUM_GPIO-1:0] din_sync, in_s, in_d, rise, fall, clr, wr_bits;
    logic [CFG_TOT-1:0]  cfg_q;
    logic [CFG_PAD-1:0]  cfg_pad, cfg_wr;
    logic                wr_pend;
    logic [REG_AW-1:0]   wr_addr;
    logic [REG_DW-1:0]   wr_data;
    logic [REG_DW-1:0]   rd_mux, rdata_q;
    logic                rvalid_q, irq_q, ready, rd_fire, wr_fire;

    gpio_sync #(.WIDTH(NUM_GPIO)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_din),
        .q   (din_sync)
    );

    assign ready   = ~(rvalid_q & ~reg_port.reg_rready);
    assign rd_fire = reg_port.reg_valid & ready & ~reg_port.reg_write;
    assign wr_fire = reg_port.reg_valid & ready &  reg_port.reg_write;

    assign reg_port.reg_ready  = ready;
    assign reg_port.reg_rvalid = rvalid_q;
    assign reg_port.reg_rdata  = rdata_q;

    assign pad_dout = out_q;
    assign pad_oen  = oen_q;
    assign pad_ie   = ie_q;
    assign pad_cfg  = cfg_q;
    assign irq      = irq_q;

    assign rise    = in_s & ~in_d & rise_en_q;
    assign fall    = ~in_s & in_d & fall_en_q;
    assign wr_bits = wr_data[NUM_GPIO-1:0];
    assign clr     = (wr_pend && wr_addr == ADDR_STATUS) ? wr_bits : '0;

    // Config is viewed as a zero-padded 8-word space so CFG slices beyond pad_cfg read 0
    always_comb begin
        cfg_pad                                  = '0;
        cfg_pad[CFG_TOT-1:0]                     = cfg_q;
        cfg_wr                                   = cfg_pad;
        cfg_wr[wr_addr[2:0]*REG_DW +: REG_DW]    = wr_data;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_port.reg_addr)
            ADDR_OUT:     rd_mux[NUM_GPIO-1:0] = out_q;
            ADDR_OEN:     rd_mux[NUM_GPIO-1:0] = oen_q;
            ADDR_IE:      rd_mux[NUM_GPIO-1:0] = ie_q;
            ADDR_IN:      rd_mux[NUM_GPIO-1:0] = in_s;
            ADDR_RISE_EN: rd_mux[NUM_GPIO-1:0] = rise_en_q;
            ADDR_FALL_EN: rd_mux[NUM_GPIO-1:0] = fall_en_q;
            ADDR_STATUS:  rd_mux[NUM_GPIO-1:0] = status_q;
            default: begin
                if (is_cfg_addr(reg_port.reg_addr))
                    rd_mux = cfg_pad[reg_port.reg_addr[2:0]*REG_DW +: REG_DW];
            end
        endcase
    end

    // Writes are captured at accept and applied on the following edge
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            oen_q     <= '1;
            ie_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            cfg_q     <= '0;
            in_s      <= '0;
            in_d      <= '0;
            irq_q     <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            in_s     <= din_sync & ie_q;
            in_d     <= in_s;
            status_q <= (status_q & ~clr) | rise | fall;
            irq_q    <= |(status_q & (rise_en_q | fall_en_q));

            wr_pend <= wr_fire;
            if (wr_fire) begin
                wr_addr <= reg_port.reg_addr;
                wr_data <= reg_port.reg_wdata;
            end

            if (wr_pend) begin
                case (wr_addr)
                    ADDR_OUT:     out_q     <= wr_bits;
                    ADDR_OEN:     oen_q     <= wr_bits;
                    ADDR_IE:      ie_q      <= wr_bits;
                    ADDR_RISE_EN: rise_en_q <= wr_bits;
                    ADDR_FALL_EN: fall_en_q <= wr_bits;
                    default: begin
                        if (is_cfg_addr(wr_addr))
                            cfg_q <= cfg_wr[CFG_TOT-1:0];
                    end
                endcase
            end

            if (rd_fire) begin
                rdata_q  <= rd_mux;
                rvalid_q <= 1'b1;
            end else if (reg_port.reg_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
